// File: rtl/rng_pkg.sv
// Shared LFSR definitions for the random-number scheduler: polynomial, word type,
// single/multi-step next-state functions and the scheduler state encoding.
package rng_pkg;

  localparam int          RNG_W    = 16;
  localparam logic [15:0] RNG_POLY = 16'h01EE;

  typedef logic [RNG_W-1:0] rng_word_t;

  typedef enum logic {WARMUP, SERVE} rng_state_e;

  // Galois right-shift step; a nonzero state never maps to zero.
  function automatic rng_word_t rng_step(rng_word_t v);
    return {v[0], v[15:1]} ^ ({16{v[0]}} & RNG_POLY);
  endfunction

  // n steps (n <= 4) unrolled into one combinational cone.
  function automatic rng_word_t rng_step_n(rng_word_t v, int n);
    rng_word_t r;
    r = v;
    for (int i = 0; i < 4; i++)
      if (i < n) r = rng_step(r);
    return r;
  endfunction

endpackage

// File: rtl/rng_sched_if.sv
// Requester-side bus of the shared LFSR: level requests in, one-hot grant plus
// random word out, and the reseed strobe.
interface rng_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] rnd;
  logic             busy;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;

  modport master (output req, seed_load, seed_in, input gnt, rnd, busy);
  modport slave  (input req, seed_load, seed_in, output gnt, rnd, busy);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr (wrapping),
// one-hot grant and the pointer value just past the winner.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] nxt_ptr,
  output logic          any
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    nxt_ptr = ptr;
    any     = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        nxt_ptr  = PW'((int'(idx) + 1) % N);
      end
    end
  end

endmodule

// File: rtl/rng_sched.sv
// One 16-bit Galois LFSR shared by NREQ requesters through a round-robin arbiter,
// with a warm-up sequencer after reset. Reseeding is built only with RNG_SCHED_RESEED_EN.
module rng_sched
  import rng_pkg::*;
#(
  parameter int          NREQ   = 4,
  parameter int          WIDTH  = 16,
  parameter logic [15:0] SEED   = 16'hdead,
  parameter int          WARMUP = 32,
  parameter int          STRIDE = 1
) (
  input logic        clk,
  input logic        rst_n,
  rng_sched_if.slave bus
);

  localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int              CW       = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam rng_state_e      ST_INIT  = (WARMUP != 0) ? rng_pkg::WARMUP : rng_pkg::SERVE;

  if (WIDTH != RNG_W) begin : g_bad_width
    $error("rng_sched: WIDTH must be 16");
  end
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("rng_sched: NREQ must be 2..16");
  end
  if (STRIDE < 1 || STRIDE > 4) begin : g_bad_stride
    $error("rng_sched: STRIDE must be 1..4");
  end
  if (SEED == 16'h0) begin : g_bad_seed
    $error("rng_sched: SEED must be nonzero");
  end

  rng_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  rng_word_t       lfsr_q, lfsr_d;
  rng_word_t       rnd_q, rnd_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic [NREQ-1:0] req_eff, arb_gnt;
  logic [PW-1:0]   arb_ptr;
  logic            arb_any;

  // The requester still sees its own grant this cycle; don't serve it twice.
  assign req_eff = bus.req & ~gnt_q;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (req_eff),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .nxt_ptr (arb_ptr),
    .any     (arb_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    ptr_d   = ptr_q;
    case (state_q)
      rng_pkg::WARMUP: begin
        lfsr_d = rng_step(lfsr_q);
        if (cnt_q == '0) state_d = rng_pkg::SERVE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      rng_pkg::SERVE: begin
        if (arb_any) begin
          gnt_d  = arb_gnt;
          rnd_d  = lfsr_q;
          lfsr_d = rng_step_n(lfsr_q, STRIDE);
          ptr_d  = arb_ptr;
        end
      end
      default: state_d = ST_INIT;
    endcase
`ifdef RNG_SCHED_RESEED_EN
    // Reseed wins over everything; a zero seed would lock the LFSR, so fall back.
    if (bus.seed_load) begin
      lfsr_d  = (bus.seed_in == '0) ? SEED : bus.seed_in;
      gnt_d   = '0;
      rnd_d   = rnd_q;
      ptr_d   = ptr_q;
      state_d = ST_INIT;
      cnt_d   = CNT_INIT;
    end
`endif
  end

`ifndef RNG_SCHED_RESEED_EN
  logic unused_seed;
  assign unused_seed = ^{bus.seed_load, bus.seed_in};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= CNT_INIT;
      lfsr_q  <= SEED;
      rnd_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      rnd_q   <= rnd_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.rnd  = rnd_q;
  assign bus.busy = (state_q == rng_pkg::WARMUP);

endmodule

// File: tb/tb_rng_sched.sv
// Two schedulers (no warm-up/stride 1 and warm-up 32/stride 2) checked every cycle
// against a behavioural model, plus directed and random-request scenarios.
module tb_rng_sched;

  logic        clk;
  logic        rst0_n, rst1_n;
  logic [3:0]  req0, req1;
  logic        sl0, sl1;
  logic [15:0] seed0, seed1;

  int n_chk = 0;
  int n_err = 0;

  rng_sched_if #(.NREQ(4), .WIDTH(16)) if0 ();
  rng_sched_if #(.NREQ(4), .WIDTH(16)) if1 ();

  assign if0.req = req0;  assign if0.seed_load = sl0;  assign if0.seed_in = seed0;
  assign if1.req = req1;  assign if1.seed_load = sl1;  assign if1.seed_in = seed1;

  rng_sched #(.NREQ(4), .WIDTH(16), .SEED(16'hdead), .WARMUP(0), .STRIDE(1)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .bus(if0));
  rng_sched #(.NREQ(4), .WIDTH(16), .SEED(16'hdead), .WARMUP(32), .STRIDE(2)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_lfsr [2];
  logic [15:0] m_rnd  [2];
  int          m_ptr  [2];
  int          m_warm [2];   // warm-up steps still to run
  int          m_gidx [2];   // requester shown as granted, -1 if none
  logic [15:0] dead32;

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'h81EE;
    return r;
  endfunction

  function automatic int wu(input int k);     return (k == 0) ? 0 : 32; endfunction
  function automatic int stride(input int k); return (k == 0) ? 1 : 2;  endfunction
  function automatic bit bitn(input logic [3:0] v, input int i); return v[i[1:0]]; endfunction

  function automatic logic [31:0] exp_gnt(input int k);
    return (m_gidx[k] < 0) ? 32'h0 : (32'h1 << m_gidx[k]);
  endfunction

  task automatic model_edge(input int k);
    logic [3:0] eff;
    logic       rst;
    rst = (k == 0) ? rst0_n : rst1_n;
    if (!rst) begin
      m_lfsr[k] = 16'hDEAD; m_rnd[k] = 16'h0; m_ptr[k] = 0;
      m_warm[k] = wu(k);    m_gidx[k] = -1;
      return;
    end
`ifdef RNG_SCHED_RESEED_EN
    if ((k == 0) ? sl0 : sl1) begin
      m_lfsr[k] = (k == 0) ? seed0 : seed1;
      if (m_lfsr[k] == 16'h0) m_lfsr[k] = 16'hDEAD;
      m_gidx[k] = -1;
      m_warm[k] = wu(k);
      return;
    end
`endif
    if (m_warm[k] > 0) begin
      m_lfsr[k] = ref_step(m_lfsr[k]);
      m_warm[k]--;
      m_gidx[k] = -1;
      return;
    end
    eff = (k == 0) ? req0 : req1;
    if (m_gidx[k] >= 0) eff = eff & ~(4'b1 << m_gidx[k]);
    m_gidx[k] = -1;
    for (int j = 0; j < 4; j++) begin
      int i;
      i = (m_ptr[k] + j) % 4;
      if (bitn(eff, i)) begin
        m_gidx[k] = i;
        m_rnd[k]  = m_lfsr[k];
        for (int q = 0; q < stride(k); q++) m_lfsr[k] = ref_step(m_lfsr[k]);
        m_ptr[k] = (i + 1) % 4;
        break;
      end
    end
  endtask

  // Cycle scoreboard: advance model at each edge, compare 1 time unit later.
  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
    #1;
    chk("sb0_gnt",  32'(if0.gnt),  exp_gnt(0));
    chk("sb0_rnd",  32'(if0.rnd),  32'(m_rnd[0]));
    chk("sb0_busy", 32'(if0.busy), 32'(m_warm[0] > 0));
    chk("sb1_gnt",  32'(if1.gnt),  exp_gnt(1));
    chk("sb1_rnd",  32'(if1.rnd),  32'(m_rnd[1]));
    chk("sb1_busy", 32'(if1.busy), 32'(m_warm[1] > 0));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Directed single/alternating/wrap patterns on the no-warm-up instance.
  task automatic d0_script(input int n);
    case (n)
      1: begin chk("t1_gnt_a", 32'(if0.gnt), 32'h1); chk("t1_rnd_a", 32'(if0.rnd), 32'hDEAD); end
      2: chk("t1_masked", 32'(if0.gnt), 32'h0);
      3: begin
        chk("t1_gnt_b", 32'(if0.gnt), 32'h1);
        chk("t1_rnd_b", 32'(if0.rnd), 32'hEEB8);
        req0 = 4'b1010;
      end
      default: ;
    endcase
    if (n >= 4 && n <= 11) chk("t3_alt", 32'(if0.gnt), (n % 2 == 0) ? 32'h2 : 32'h8);
    if (n == 11) req0 = 4'b1001;
    if (n >= 12 && n <= 15) chk("t3_wrap", 32'(if0.gnt), (n % 2 == 0) ? 32'h1 : 32'h8);
    if (n == 15) req0 = 4'b0000;
  endtask

  // Warm-up length, first word and grant order of the warm-up instance (req1=1111).
  task automatic warm_check(input bit with_d0);
    int idle_at;
    int g1n;
    idle_at = -1;
    g1n     = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (idle_at < 0 && !if1.busy) idle_at = n;
      if (if1.busy) chk("t2_busy_nogrant", 32'(if1.gnt), 32'h0);
      else if (if1.gnt != 4'b0 && g1n < 5) begin
        if (g1n == 0) chk("t2_first_rnd", 32'(if1.rnd), 32'(dead32));
        chk("t2_order", 32'(if1.gnt), 32'h1 << (g1n % 4));
        g1n++;
      end
      if (with_d0) d0_script(n);
    end
    chk("t2_busy_len", 32'(idle_at), 32'd32);
    chk("t2_grant_cnt", 32'(g1n), 32'd5);
  endtask

  int wt [2][4];

  task automatic stress_obs(input int k, input logic [3:0] g, input logic [15:0] rv);
    logic [3:0] r;
    r = (k == 0) ? req0 : req1;
    chk("t6_onehot", 32'($onehot0(g)), 32'h1);
    if (g != 4'b0) chk("t6_rnd_nz", 32'(rv == 16'h0), 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (bitn(g, i)) begin
        chk("t6_starve", 32'(wt[k][i] > 4), 32'h0);
        wt[k][i] = 0;
        if ($urandom_range(0, 3) != 0) r = r & ~(4'b1 << i);
      end else if (bitn(r, i)) begin
        if (g != 4'b0) wt[k][i]++;
      end else if ($urandom_range(0, 2) == 0) begin
        r = r | (4'b1 << i);
        wt[k][i] = 0;
      end
    end
    if (k == 0) req0 = r; else req1 = r;
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    req0 = '0; req1 = '0; sl0 = 1'b0; sl1 = 1'b0; seed0 = '0; seed1 = '0;
    dead32 = 16'hDEAD;
    repeat (32) dead32 = ref_step(dead32);

    // Reset state
    tick();
    tick();
    chk("rst_gnt1",  32'(if1.gnt),  32'h0);
    chk("rst_rnd1",  32'(if1.rnd),  32'h0);
    chk("rst_busy1", 32'(if1.busy), 32'h1);
    chk("rst_busy0", 32'(if0.busy), 32'h0);

    // Tests 1-3: requests present from the first cycle after reset
    rst0_n = 1'b1; rst1_n = 1'b1;
    req0 = 4'b0001; req1 = 4'b1111;
    warm_check(1'b1);

    // Test 4: reseed during a grant cycle
    req0 = 4'b0011;
    tick();
    chk("t4_pre_gnt", 32'(if0.gnt), 32'h1);
    sl0 = 1'b1; seed0 = 16'h0000;
    tick();
`ifdef RNG_SCHED_RESEED_EN
    sl0 = 1'b0;
    chk("t4_drop", 32'(if0.gnt), 32'h0);
    tick();
    chk("t4_zero_gnt", 32'(if0.gnt), 32'h2);
    chk("t4_zero_rnd", 32'(if0.rnd), 32'hDEAD);
    sl0 = 1'b1; seed0 = 16'h1234;
    tick();
    sl0 = 1'b0;
    chk("t4_drop2", 32'(if0.gnt), 32'h0);
    tick();
    chk("t4_seed_rnd", 32'(if0.rnd), 32'h1234);
`else
    sl0 = 1'b0;
    chk("t4_ignored", 32'(if0.gnt), 32'h2);
    tick();
`endif
    req0 = 4'b0000;
    tick();

    // Test 5: async reset in a grant cycle, then mid-warm-up
    tick();
    chk("t5_in_grant", 32'(if1.gnt != 4'b0), 32'h1);
    #1 rst1_n = 1'b0;
    #1;
    chk("t5_g_gnt",  32'(if1.gnt),  32'h0);
    chk("t5_g_rnd",  32'(if1.rnd),  32'h0);
    chk("t5_g_busy", 32'(if1.busy), 32'h1);
    tick();
    rst1_n = 1'b1;
    repeat (10) tick();
    #1 rst1_n = 1'b0;
    #1;
    chk("t5_w_gnt",  32'(if1.gnt),  32'h0);
    chk("t5_w_rnd",  32'(if1.rnd),  32'h0);
    chk("t5_w_busy", 32'(if1.busy), 32'h1);
    tick();
    rst1_n = 1'b1;
    warm_check(1'b0);

    // Test 6: random request stress with occasional reseed strobes
    req0 = '0; req1 = '0;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) wt[k][i] = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      stress_obs(0, if0.gnt, if0.rnd);
      stress_obs(1, if1.gnt, if1.rnd);
      sl0   = ($urandom_range(0, 199) == 0);
      sl1   = ($urandom_range(0, 199) == 0);
      seed0 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      seed1 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    end
    sl0 = 1'b0; sl1 = 1'b0; req0 = '0; req1 = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
